stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Multicycle instruction sequencer that generates the 3-bit Stage code (1=Fetch, 2=Decode, 3=Execute, 4=Memory, 5=Write Back, 0=idle) consumed by the stage-enable decoder.
- Inserts memory wait states, supports run, single-step and halt, and detects memory timeout.
- Keeps cycle and retired-instruction counters for debug.
- Sits between the top-level run/debug controls, the memory ready line and the stage-enable decoder.

Parameters:
- CNT_W, 16, width of Cycle_Count and Instr_Count.
- WAIT_LIMIT, 15, maximum consecutive wait cycles on one stall before Fault; must be ≥1 and < 2^8.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  level-sampled; launches execution from IDLE or HALTED.
- Step_Mode  input  1  1 = return to IDLE after each instruction.
- Halt_Req  input  1  level-sampled; stop after the current instruction retires.
- Mem_Ready  input  1  memory has completed the current access.
- Mem_Access_Memory_Stage  input  1  current instruction accesses memory in stage 4. Driven high when the memory-stage code ≠ 0.
- Stage  output  3  current stage code, 0..5.
- Busy  output  1  1 when Stage ≠ 0.
- Stall  output  1  1 in any cycle where Stage is held by a wait.
- Instr_Done  output  1  one-cycle pulse after an instruction retires.
- Halted  output  1  1 in HALTED state.
- Fault  output  1  sticky timeout flag; cleared only by reset.
- Cycle_Count  output  CNT_W  count of cycles with Busy=1; wraps.
- Instr_Count  output  CNT_W  count of retired instructions; wraps.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=IDLE.
  - Stage=0; Busy, Stall, Instr_Done, Halted and Fault = 0.
  - Both counters and the wait counter = 0.
  - Deassertion takes effect on the next rising edge.
- States: IDLE, RUN, HALTED. Stage, Halted and Instr_Done are registered; Busy = (Stage ≠ 0). Stall is combinational from the current Stage, Mem_Ready and Mem_Access_Memory_Stage.
- IDLE / HALTED: Stage=0.
  - Start=1 at an edge → RUN with Stage=1 on the next cycle.
  - Halted clears on the same edge.
  - In HALTED with Fault=1, Start is ignored.
- RUN advance: each edge Stage goes 1→2→3→4→5, unless stalled.
- Stall conditions:
  - Stage=1 and Mem_Ready=0 (instruction fetch wait).
  - Stage=4 and Mem_Access_Memory_Stage=1 and Mem_Ready=0 (data access wait).
  - Stages 2, 3 and 5 never stall; Mem_Ready is ignored there.
- Wait counter:
  - Increments on each stalled edge.
  - Clears on any edge where Stage advances.
  - When a stall edge would make the count equal WAIT_LIMIT: set Fault, enter HALTED (Stage=0, Halted=1), no retire.
- Retire: the edge leaving Stage=5 retires the instruction.
  - Instr_Done=1 for exactly the following cycle.
  - Instr_Count increments on that edge.
- Next state on retire, in priority order:
  1. Halt_Req=1 → HALTED, Stage=0, Halted=1.
  2. Else Step_Mode=1 → IDLE, Stage=0.
  3. Else Stage=1 (back-to-back, no bubble).
- Halt_Req asserted mid-instruction is not honoured early. Only its value at the retire edge matters.
- Cycle_Count: increments on every edge where Stage ≠ 0 before the edge, stalled cycles included. Both counters wrap from 2^CNT_W−1 to 0 with no flag.
- Start while RUN: ignored.
- Priority on simultaneous events: Reset > timeout Fault > Halt_Req > Step_Mode > continue.
- Reset mid-instruction: aborts immediately to IDLE. No Instr_Done pulse; counters cleared.
- Stage values 6 and 7 are never driven. If the Stage register is ever observed at 6 or 7, next edge → IDLE (Stage=0).

Test Plan:
- Free run:
  - Stimulus: Reset released, Mem_Ready=1, Start=1 held, Step_Mode=0, no halt.
  - Required: Stage sequence 1,2,3,4,5,1,2,…; Instr_Done pulses every 5 cycles; after 20 busy cycles Cycle_Count=20 and Instr_Count=4.
- Fetch wait:
  - Stimulus: Mem_Ready=0 for 3 cycles while Stage=1.
  - Required: Stage held at 1 for 4 cycles with Stall=1 during the wait; instruction takes 8 cycles; Cycle_Count includes the 3 stall cycles.
- Memory-stage wait versus no-access:
  - Stimulus: Stage=4 with Mem_Access_Memory_Stage=1 and Mem_Ready=0 for 2 cycles; repeat with Mem_Access_Memory_Stage=0.
  - Required: first case holds Stage 4 for 2 extra cycles; second case advances with no stall.
- Step and halt:
  - Stimulus: Step_Mode=1, Start pulse.
  - Required: exactly one 1..5 pass, then Stage=0 and Instr_Count=1.
  - Stimulus: Halt_Req raised at Stage=2.
  - Required: instruction completes, then Halted=1 and Stage=0; next Start resumes at Stage=1.
- Timeout:
  - Stimulus: WAIT_LIMIT=15, Mem_Ready stuck 0 at Stage=1.
  - Required: after 15 stall edges, Fault=1, Halted=1, Stage=0, no Instr_Done; Start is ignored; Reset clears everything.
- Reset mid-operation and wrap:
  - Stimulus: Reset asserted at Stage=3.
  - Required: Stage=0 immediately (asynchronous) and counters=0.
  - Stimulus: with CNT_W=4, run 16 instructions.
  - Required: Instr_Count wraps to 0.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle instruction sequencer that emits the stage
// code (1=Fetch 2=Decode 3=Execute 4=Memory 5=WriteBack, 0=idle).
// It inserts memory wait states, supports run/single-step/halt, flags a
// memory timeout, and keeps cycle and retired-instruction debug counters.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   start_i                launch from IDLE or HALTED (ignored while running)
//   step_mode_i            return to IDLE after each retired instruction
//   halt_req_i             sampled at the retire edge; stop after retire
//   mem_ready_i            memory completed the current access
//   mem_access_mem_i       current instruction accesses memory in stage 4
//   stage_o                current stage code 0..5
//   busy_o                 stage_o != 0
//   stall_o                stage held by a memory wait this cycle
//   instr_done_o           one-cycle pulse after an instruction retires
//   halted_o               in HALTED state
//   fault_o                sticky wait timeout flag (cleared by reset only)
//   cycle_count_o          busy cycles, wraps
//   instr_count_o          retired instructions, wraps
module stage_sequencer #(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             step_mode_i,
  input  logic             halt_req_i,
  input  logic             mem_ready_i,
  input  logic             mem_access_mem_i,
  output logic [2:0]       stage_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             instr_done_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

  state_e           state_q;
  logic [2:0]       stage_q;
  logic [7:0]       wait_q;
  logic [7:0]       wait_d;
  logic             instr_done_q;
  logic             halted_q;
  logic             fault_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             stall;

  // Fetch always waits on memory; the memory stage only when it accesses it.
  assign stall = ((stage_q == 3'd1) && !mem_ready_i) ||
                 ((stage_q == 3'd4) && mem_access_mem_i && !mem_ready_i);

  assign wait_d = wait_q + 8'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      stage_q      <= 3'd0;
      wait_q       <= 8'd0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      instr_done_q <= 1'b0;
      if (stage_q != 3'd0) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);

      case (state_q)
        S_IDLE, S_HALTED: begin
          stage_q <= 3'd0;
          wait_q  <= 8'd0;
          // A faulted sequencer stays parked until reset.
          if (start_i && !fault_q) begin
            state_q  <= S_RUN;
            stage_q  <= 3'd1;
            halted_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (stage_q == 3'd0 || stage_q > 3'd5) begin
            // Illegal code: recover to IDLE.
            state_q <= S_IDLE;
            stage_q <= 3'd0;
            wait_q  <= 8'd0;
          end else if (stall) begin
            if (wait_d == WAIT_LIM) begin
              fault_q  <= 1'b1;
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
              stage_q  <= 3'd0;
              wait_q   <= 8'd0;
            end else begin
              wait_q <= wait_d;
            end
          end else begin
            wait_q <= 8'd0;
            if (stage_q == 3'd5) begin
              instr_done_q <= 1'b1;
              instr_cnt_q  <= instr_cnt_q + CNT_W'(1);
              if (halt_req_i) begin
                state_q  <= S_HALTED;
                stage_q  <= 3'd0;
                halted_q <= 1'b1;
              end else if (step_mode_i) begin
                state_q <= S_IDLE;
                stage_q <= 3'd0;
              end else begin
                stage_q <= 3'd1;
              end
            end else begin
              stage_q <= stage_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          stage_q <= 3'd0;
          wait_q  <= 8'd0;
        end
      endcase
    end
  end

  assign stage_o       = stage_q;
  assign busy_o        = (stage_q != 3'd0);
  assign stall_o       = stall;
  assign instr_done_o  = instr_done_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;
  assign cycle_count_o = cycle_cnt_q;
  assign instr_count_o = instr_cnt_q;

endmodule
